// File: rtl/gpr_writeback.sv
// Write-back arbiter and FIFO feeding the single GPR write port; idle output is a write to x0.
// Optional store-to-read forwarding is enabled by defining GPR_WB_FORWARD_EN.
module gpr_writeback #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  alu_valid_in,
    output logic                  alu_ready_out,
    input  logic [ADDR_WIDTH-1:0] alu_rd_addr_in,
    input  logic [DATA_WIDTH-1:0] alu_rd_data_in,
    input  logic                  lsu_valid_in,
    output logic                  lsu_ready_out,
    input  logic [ADDR_WIDTH-1:0] lsu_rd_addr_in,
    input  logic [DATA_WIDTH-1:0] lsu_rd_data_in,
    input  logic                  stall_in,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_valid_out,
    output logic [2:0]            pending_out,
    input  logic [ADDR_WIDTH-1:0] fwd_addr_in,
    output logic                  fwd_hit_out,
    output logic [DATA_WIDTH-1:0] fwd_data_out
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {GrantAlu, GrantLsu} grant_e;

    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    grant_e                last_grant_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    logic                  space, contend, alu_fire, lsu_fire, push, pop;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [DATA_WIDTH-1:0] push_data;

    // Readies use the pre-pop count, so a full FIFO refuses for one cycle even while popping.
    assign space         = reset_in && (count_q < CW'(FIFO_DEPTH));
    assign contend       = alu_valid_in && lsu_valid_in;
    assign alu_ready_out = space && !(contend && last_grant_q == GrantAlu);
    assign lsu_ready_out = space && !(contend && last_grant_q == GrantLsu);

    assign alu_fire  = alu_valid_in && alu_ready_out;
    assign lsu_fire  = lsu_valid_in && lsu_ready_out;
    assign push_addr = lsu_fire ? lsu_rd_addr_in : alu_rd_addr_in;
    assign push_data = lsu_fire ? lsu_rd_data_in : alu_rd_data_in;
    // x0 handshakes complete but never occupy a slot.
    assign push      = (alu_fire || lsu_fire) && (push_addr != '0);
    assign pop       = !stall_in && (count_q != '0);

    always_ff @(posedge clock_in) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= push_addr;
            mem_data[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= GrantAlu;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);
            if (contend && (alu_fire || lsu_fire)) begin
                last_grant_q <= lsu_fire ? GrantLsu : GrantAlu;
            end
            if (pop) begin
                rd_addr_q  <= mem_addr[rd_ptr_q];
                rd_data_q  <= mem_data[rd_ptr_q];
                rd_valid_q <= 1'b1;
            end else begin
                rd_addr_q  <= '0;
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign rd_addr_out  = rd_addr_q;
    assign rd_data_out  = rd_data_q;
    assign rd_valid_out = rd_valid_q;
    assign pending_out  = 3'(count_q);

`ifdef GPR_WB_FORWARD_EN
    logic [PW-1:0] idx;

    // Scan oldest to youngest so the last match wins: output register, then head..tail.
    always_comb begin
        fwd_hit_out  = 1'b0;
        fwd_data_out = '0;
        idx          = '0;
        if (fwd_addr_in != '0) begin
            if (rd_valid_q && rd_addr_q == fwd_addr_in) begin
                fwd_hit_out  = 1'b1;
                fwd_data_out = rd_data_q;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if (CW'(i) < count_q && mem_addr[idx] == fwd_addr_in) begin
                    fwd_hit_out  = 1'b1;
                    fwd_data_out = mem_data[idx];
                end
            end
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr_in;
    assign fwd_hit_out     = 1'b0;
    assign fwd_data_out    = '0;
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed self-checking bench for gpr_writeback: reset, latency, arbitration, full, x0, forwarding.
module tb_gpr_writeback;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        alu_valid_in, lsu_valid_in, stall_in;
    logic        alu_ready_out, lsu_ready_out;
    logic [4:0]  alu_rd_addr_in, lsu_rd_addr_in, rd_addr_out, fwd_addr_in;
    logic [31:0] alu_rd_data_in, lsu_rd_data_in, rd_data_out, fwd_data_out;
    logic        rd_valid_out, fwd_hit_out;
    logic [2:0]  pending_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock_in = ~clock_in;

    gpr_writeback dut (
        .clock_in       (clock_in),
        .reset_in       (reset_in),
        .alu_valid_in   (alu_valid_in),
        .alu_ready_out  (alu_ready_out),
        .alu_rd_addr_in (alu_rd_addr_in),
        .alu_rd_data_in (alu_rd_data_in),
        .lsu_valid_in   (lsu_valid_in),
        .lsu_ready_out  (lsu_ready_out),
        .lsu_rd_addr_in (lsu_rd_addr_in),
        .lsu_rd_data_in (lsu_rd_data_in),
        .stall_in       (stall_in),
        .rd_addr_out    (rd_addr_out),
        .rd_data_out    (rd_data_out),
        .rd_valid_out   (rd_valid_out),
        .pending_out    (pending_out),
        .fwd_addr_in    (fwd_addr_in),
        .fwd_hit_out    (fwd_hit_out),
        .fwd_data_out   (fwd_data_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    initial begin
        int li, ai;
        logic [4:0] seq [4];
        seq[0] = 5'd1; seq[1] = 5'd11; seq[2] = 5'd2; seq[3] = 5'd12;

        // T1: reset with both producers requesting
        reset_in = 1'b0; stall_in = 1'b0; fwd_addr_in = '0;
        alu_valid_in = 1'b1; alu_rd_addr_in = 5'd3; alu_rd_data_in = 32'h33;
        lsu_valid_in = 1'b1; lsu_rd_addr_in = 5'd4; lsu_rd_data_in = 32'h44;
        for (int e = 0; e < 2; e++) begin
            tick();
            check("rst_alu_ready", 32'(alu_ready_out), 32'd0);
            check("rst_lsu_ready", 32'(lsu_ready_out), 32'd0);
            check("rst_rd_valid", 32'(rd_valid_out), 32'd0);
            check("rst_rd_addr", 32'(rd_addr_out), 32'd0);
            check("rst_pending", 32'(pending_out), 32'd0);
        end
        reset_in = 1'b1; alu_valid_in = 1'b0; lsu_valid_in = 1'b0;

        // T2: single ALU write, one-cycle visibility
        alu_valid_in = 1'b1; alu_rd_addr_in = 5'd5; alu_rd_data_in = 32'hDEADBEEF;
        #1 check("t2_alu_ready", 32'(alu_ready_out), 32'd1);
        tick();
        alu_valid_in = 1'b0;
        check("t2_pending_k", 32'(pending_out), 32'd1);
        check("t2_valid_k", 32'(rd_valid_out), 32'd0);
        tick();
        check("t2_addr_k1", 32'(rd_addr_out), 32'd5);
        check("t2_data_k1", rd_data_out, 32'hDEADBEEF);
        check("t2_valid_k1", 32'(rd_valid_out), 32'd1);
        tick();
        check("t2_addr_k2", 32'(rd_addr_out), 32'd0);
        check("t2_valid_k2", 32'(rd_valid_out), 32'd0);

        // T3: contention, producers hold their request until accepted
        li = 1; ai = 11;
        alu_valid_in = 1'b1; lsu_valid_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            lsu_rd_addr_in = 5'(li); lsu_rd_data_in = 32'h100 + 32'(li);
            alu_rd_addr_in = 5'(ai); alu_rd_data_in = 32'h100 + 32'(ai);
            #1;
            check("t3_lsu_ready", 32'(lsu_ready_out), (c % 2 == 0) ? 32'd1 : 32'd0);
            check("t3_alu_ready", 32'(alu_ready_out), (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c % 2 == 0) li++; else ai++;
            tick();
            if (c > 0) begin
                check("t3_order", 32'(rd_addr_out), 32'(seq[c-1]));
                check("t3_data", rd_data_out, 32'h100 + 32'(seq[c-1]));
            end
        end
        alu_valid_in = 1'b0; lsu_valid_in = 1'b0;
        tick();
        check("t3_order_last", 32'(rd_addr_out), 32'(seq[3]));
        tick();
        check("t3_drained", 32'(rd_valid_out), 32'd0);
        check("t3_pending", 32'(pending_out), 32'd0);

        // T4: stalled fill to full, then drain in order
        stall_in = 1'b1; alu_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alu_rd_addr_in = 5'(20 + i); alu_rd_data_in = 32'(i);
            #1 check("t4_alu_ready", 32'(alu_ready_out), (i < 4) ? 32'd1 : 32'd0);
            tick();
            check("t4_stalled_valid", 32'(rd_valid_out), 32'd0);
        end
        check("t4_pending_full", 32'(pending_out), 32'd4);
        lsu_valid_in = 1'b1; lsu_rd_addr_in = 5'd9;
        #1 check("t4_lsu_ready_full", 32'(lsu_ready_out), 32'd0);
        alu_valid_in = 1'b0; lsu_valid_in = 1'b0; stall_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_drain_addr", 32'(rd_addr_out), 32'(20 + i));
            check("t4_drain_data", rd_data_out, 32'(i));
            check("t4_drain_valid", 32'(rd_valid_out), 32'd1);
            check("t4_drain_pending", 32'(pending_out), 32'(3 - i));
        end
        tick();
        check("t4_idle_valid", 32'(rd_valid_out), 32'd0);

        // T5: x0 write completes handshake but is dropped
        lsu_valid_in = 1'b1; lsu_rd_addr_in = 5'd0; lsu_rd_data_in = 32'h1234;
        #1 check("t5_lsu_ready", 32'(lsu_ready_out), 32'd1);
        tick();
        lsu_valid_in = 1'b0;
        check("t5_pending", 32'(pending_out), 32'd0);
        check("t5_valid0", 32'(rd_valid_out), 32'd0);
        tick();
        check("t5_valid1", 32'(rd_valid_out), 32'd0);

`ifdef GPR_WB_FORWARD_EN
        // T6: youngest match forwarded, x0 never hits
        stall_in = 1'b1; alu_valid_in = 1'b1;
        alu_rd_addr_in = 5'd7; alu_rd_data_in = 32'hA;
        tick();
        alu_rd_data_in = 32'hB;
        tick();
        alu_valid_in = 1'b0;
        fwd_addr_in = 5'd7;
        #1 check("t6_hit", 32'(fwd_hit_out), 32'd1);
        check("t6_data", fwd_data_out, 32'hB);
        fwd_addr_in = 5'd0;
        #1 check("t6_x0_hit", 32'(fwd_hit_out), 32'd0);
        fwd_addr_in = 5'd8;
        #1 check("t6_miss", 32'(fwd_hit_out), 32'd0);
        fwd_addr_in = 5'd7; stall_in = 1'b0;
        tick();
        check("t6_rd_a", rd_data_out, 32'hA);
        check("t6_hit_mixed", fwd_data_out, 32'hB);
        tick();
        check("t6_hit_outreg", 32'(fwd_hit_out), 32'd1);
        check("t6_data_outreg", fwd_data_out, 32'hB);
        tick();
        check("t6_hit_gone", 32'(fwd_hit_out), 32'd0);
`else
        fwd_addr_in = 5'd5;
        stall_in = 1'b1; alu_valid_in = 1'b1;
        alu_rd_addr_in = 5'd5; alu_rd_data_in = 32'h55;
        tick();
        alu_valid_in = 1'b0;
        check("nofwd_hit", 32'(fwd_hit_out), 32'd0);
        check("nofwd_data", fwd_data_out, 32'd0);
        stall_in = 1'b0;
        tick();
        check("nofwd_rd", rd_data_out, 32'h55);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
